// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter among NUM_REQ delay requesters.
// Optional: define COUNTER_SCHED_ABORT_EN to let a dropped request abort its job.
module counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] len_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic                     cnt_en_o,
    output logic                     cnt_clear_o,
    input  logic [WIDTH-1:0]         cnt_count_i,
    input  logic                     cnt_overflow_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, idx_q, sel_idx;
    logic               sel_vld;
    logic [WIDTH-1:0]   len_q;
    logic               err_q, err_set;
    logic               abort;
    logic [NUM_REQ-1:0] idx_oh;

    // Scan offsets high to low so the smallest offset from ptr wins.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (req[k]) res = {1'b1, IW'(k)};
        end
        return res;
    endfunction

    assign {sel_vld, sel_idx} = rr_pick(req_i, rr_ptr_q);

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort = ((state_q == LOAD) || (state_q == RUN)) && !req_i[idx_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_en_o    = 1'b0;
        cnt_clear_o = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            IDLE: if (sel_vld) state_d = LOAD;
            LOAD: begin
                cnt_clear_o = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                cnt_en_o = (cnt_count_i != len_q);
                if (cnt_count_i == len_q) begin
                    state_d = DONE;
                end else if (cnt_overflow_i) begin
                    state_d = DONE;
                    err_set = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over any RUN outcome and leaves the counter cleared.
        if (abort) begin
            state_d     = IDLE;
            cnt_clear_o = 1'b1;
            cnt_en_o    = 1'b0;
            err_set     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sel_vld) begin
                idx_q    <= sel_idx;
                len_q    <= len_i[int'(sel_idx)*WIDTH +: WIDTH];
                rr_ptr_q <= IW'((int'(sel_idx) + 1) % NUM_REQ);
                err_q    <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign idx_oh = NUM_REQ'(1) << idx_q;
    assign gnt_o  = (state_q != IDLE) ? idx_oh : '0;
    assign done_o = (state_q == DONE) ? idx_oh : '0;
    assign err_o  = (state_q == DONE) && err_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a job-level reference model and a
// behavioural counter (MAX_COUNT=10) wired to the scheduler.
module tb_counter_sched;
    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   gnt, done;
    logic           err, busy, cen, cclr;
    logic [W-1:0]   cnt = '0;
    logic           ovf = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    counter_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len),
        .gnt_o(gnt), .done_o(done), .err_o(err), .busy_o(busy),
        .cnt_en_o(cen), .cnt_clear_o(cclr),
        .cnt_count_i(cnt), .cnt_overflow_i(ovf)
    );

    // Shared counter: sync clear over enable, wraps after M with an overflow pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; ovf <= 1'b0;
        end else if (cclr) begin
            cnt <= '0; ovf <= 1'b0;
        end else if (cen) begin
            if (cnt == W'(M)) begin cnt <= '0; ovf <= 1'b1; end
            else begin cnt <= cnt + 1'b1; ovf <= 1'b0; end
        end else begin
            ovf <= 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Job-level model: a job is (idx, len, t = cycles since grant).
    bit m_act = 0;
    int m_idx = 0, m_len = 0, m_t = 0, m_ptr = 0;
    int m_pick, m_end, m_enl;
    bit m_ab;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    assign m_pick = pick(req, m_ptr);
    assign m_end  = (m_len <= M) ? m_len + 2 : M + 3;
    assign m_enl  = (m_len <= M) ? m_len : M + 2;
`ifdef COUNTER_SCHED_ABORT_EN
    assign m_ab = m_act && (m_t < m_end) && !req[m_idx];
`else
    assign m_ab = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_ptr <= 0; m_t <= 0;
        end else if (!m_act) begin
            if (m_pick >= 0) begin
                m_act <= 1; m_idx <= m_pick; m_t <= 0;
                m_len <= int'(len[m_pick*W +: W]);
                m_ptr <= (m_pick + 1) % N;
            end
        end else if (m_t == m_end || m_ab) begin
            m_act <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic [N-1:0] e_gnt, e_done;
    logic e_err, e_busy, e_en, e_clr;
    always_comb begin
        e_gnt = '0; e_done = '0; e_err = 0; e_busy = 0; e_en = 0; e_clr = 0;
        if (m_act) begin
            e_gnt[m_idx]  = 1'b1;
            e_busy        = 1'b1;
            e_done[m_idx] = (m_t == m_end);
            e_err         = (m_t == m_end) && (m_len > M);
            e_clr         = (m_t == 0) || m_ab;
            e_en          = !m_ab && (m_t >= 1) && (m_t <= m_enl);
        end
    end

    always @(negedge clk)
        check("outputs{gnt,done,err,busy,en,clr}",
              32'({gnt, done, err, busy, cen, cclr}),
              32'({e_gnt, e_done, e_err, e_busy, e_en, e_clr}));

    task automatic drive(input logic [N-1:0] r);
        @(posedge clk); #1 req = r;
    endtask

    task automatic release_req();
        @(posedge clk); #1 req = '0;
    endtask

    task automatic wait_gnt(output int c, output logic [N-1:0] g);
        c = -1; g = '0;
        repeat (50) begin
            @(negedge clk);
            if (gnt != '0) begin c = cyc; g = gnt; return; end
        end
        check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(output int c, output logic [N-1:0] d, output logic e,
                             output logic [W-1:0] k, output bit en_seen);
        c = -1; d = '0; e = 0; k = '0; en_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (cen) en_seen = 1;
            if (done != '0) begin c = cyc; d = done; e = err; k = cnt; return; end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int gc, dc, t0, prev_dc;
        logic [N-1:0] g, d;
        logic e;
        logic [W-1:0] k;
        bit en_seen, seen;
        int exp_ord[5] = '{0, 1, 2, 3, 0};

        do_reset();
        check("reset_outputs", 32'({gnt, done, err, busy, cen, cclr}), 0);

        // Single job, len 5
        len[0 +: W] = 8'd5;
        drive(4'b0001); t0 = cyc;
        wait_gnt(gc, g);
        check("t1_gnt", 32'(g), 32'h1);
        check("t1_req_to_gnt", gc - t0, 1);
        wait_done(dc, d, e, k, en_seen);
        check("t1_done_lat", dc - gc, 7);
        check("t1_done_vec", 32'(d), 32'h1);
        check("t1_cnt_at_done", 32'(k), 5);
        check("t1_err", 32'(e), 0);
        release_req();

        // All requesting, len 2: round robin from pointer 0
        do_reset();
        len = {8'd2, 8'd2, 8'd2, 8'd2};
        drive(4'b1111);
        prev_dc = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(gc, g);
            check("t2_rr_order", 32'(g), 32'(1) << exp_ord[i]);
            if (i > 0) check("t2_grant_gap", gc - prev_dc, 2);
            wait_done(dc, d, e, k, en_seen);
            check("t2_done_vec", 32'(d), 32'(g));
            prev_dc = dc;
        end
        release_req();

        // Zero length
        len[0 +: W] = 8'd0;
        drive(4'b0001);
        wait_gnt(gc, g);
        wait_done(dc, d, e, k, en_seen);
        check("t3_done_lat", dc - gc, 2);
        check("t3_no_en", 32'(en_seen), 0);
        check("t3_err", 32'(e), 0);
        release_req();

        // Length beyond MAX_COUNT ends on overflow
        len[0 +: W] = 8'd20;
        drive(4'b0001);
        wait_gnt(gc, g);
        wait_done(dc, d, e, k, en_seen);
        check("t4_done_vec", 32'(d), 32'h1);
        check("t4_err", 32'(e), 1);
        check("t4_done_lat", dc - gc, M + 3);
        release_req();
        len[0 +: W] = 8'd3;
        drive(4'b0001);
        wait_gnt(gc, g);
        @(negedge clk);
        check("t4_next_cnt_cleared", 32'(cnt), 0);
        wait_done(dc, d, e, k, en_seen);
        check("t4_next_cnt_at_done", 32'(k), 3);
        check("t4_next_err", 32'(e), 0);
        release_req();

        // Reset mid-RUN (requester 2 leaves pointer at 3)
        len[2*W +: W] = 8'd8;
        len[1*W +: W] = 8'd1;
        len[3*W +: W] = 8'd1;
        drive(4'b0100);
        wait_gnt(gc, g);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!seen && cnt == 8'd3) seen = 1;
            if (seen) break;
        end
        check("t5_reached_cnt3", 32'(seen), 1);
        #1 rst = 1;
        #1 check("t5_async_reset_outputs", 32'({gnt, done, err, busy, cen, cclr}), 0);
        @(posedge clk); #1 rst = 0; req = 4'b1010;
        wait_gnt(gc, g);
        check("t5_gnt_after_reset", 32'(g), 32'h2);
        wait_done(dc, d, e, k, en_seen);
        check("t5_done_vec", 32'(d), 32'h2);
        release_req();

        // Drop req_i[0] at count 2 of len 8
        len[0 +: W] = 8'd8;
        drive(4'b0001);
        wait_gnt(gc, g);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cnt == 8'd1) begin seen = 1; break; end
        end
        check("t6_reached_cnt1", 32'(seen), 1);
        @(posedge clk); #1 req = '0;
`ifdef COUNTER_SCHED_ABORT_EN
        @(negedge clk);
        check("t6_abort_clear", 32'(cclr), 1);
        check("t6_abort_cnt", 32'(cnt), 2);
        @(negedge clk);
        check("t6_abort_idle", 32'({busy, gnt}), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done != '0) seen = 1;
        end
        check("t6_no_done", 32'(seen), 0);
`else
        wait_done(dc, d, e, k, en_seen);
        check("t6_done_vec", 32'(d), 32'h1);
        check("t6_cnt_at_done", 32'(k), 8);
        check("t6_err", 32'(e), 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
